rmii_rx_to_mii: RTL and testbench

RMII_RX_TO_MII -- requirements
Module: rmii_rx_to_mii

---
 rtl/rmii_rx_to_mii.sv | 179 +++++++++++++++++
 tb/tb_rmii_rx_to_mii.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rmii_rx_to_mii.sv
// rmii_rx_to_mii: RMII receive dibits to MII nibbles at 10/100 Mb/s; RMII_RX_STATS_EN enables frame/error counters
module rmii_rx_to_mii #(
    parameter int SAMPLE_PHASE = 5,
    parameter int STAT_W       = 16
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              phy2rmii_crs_dv,
    input  logic              phy2rmii_rx_er,
    input  logic [1:0]        phy2rmii_rxd,
    input  logic              speed_100,
    output logic [3:0]        mii_rxd,
    output logic              mii_rx_dv,
    output logic              mii_rx_er,
    output logic              mii_rx_clk_en,
    output logic [STAT_W-1:0] frame_cnt,
    output logic [STAT_W-1:0] err_cnt
);
    typedef enum logic [1:0] {IDLE, ALIGN, DATA, FALSE_CARRIER} state_t;

    state_t     state, nxt;
    logic       crs, rise, crs_d, armed, speed_q, fast, stb, hunt;
    logic [1:0] rxd, low, tent, n_low, n_tent;
    logic [3:0] cnt, cnt_eff, o_rxd;
    logic       have_low, low_er, pend, tent_er;
    logic       n_have, n_low_er, n_pend, n_tent_er;
    logic       emit, o_dv, o_er;

    assign crs     = phy2rmii_crs_dv;
    assign rxd     = phy2rmii_rxd;
    assign rise    = crs & ~crs_d;
    assign cnt_eff = rise ? 4'd0 : cnt;
    assign fast    = (state == IDLE) ? speed_100 : speed_q;
    assign stb     = fast | (cnt_eff == 4'(SAMPLE_PHASE));
    assign hunt    = (state == IDLE && armed) || state == ALIGN;

    // Sample phase counter, carrier edge history, speed latch and post-reset arming
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            crs_d   <= 1'b0;
            armed   <= 1'b0;
            speed_q <= 1'b0;
        end else begin
            cnt     <= (cnt_eff == 4'd9) ? 4'd0 : cnt_eff + 4'd1;
            crs_d   <= crs;
            armed   <= armed | ~crs;
            speed_q <= fast;
        end
    end

    // FSM state register
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // FSM next state; the IDLE sample that sees carrier is already judged as an ALIGN dibit
    always_comb begin
        nxt = state;
        if (stb) begin
            if (hunt)
                nxt = !crs ? IDLE : rxd == 2'b01 ? DATA : rxd == 2'b10 ? FALSE_CARRIER : ALIGN;
            else if (!crs && ((state == DATA && pend) || state == FALSE_CARRIER))
                nxt = IDLE;
        end
    end

    // Dibit assembly; a lone low-carrier dibit is held tentatively until the next sample decides its fate
    always_comb begin
        emit      = 1'b0;
        o_rxd     = 4'h0;
        o_dv      = 1'b0;
        o_er      = 1'b0;
        n_have    = have_low;
        n_low     = low;
        n_low_er  = low_er;
        n_pend    = pend;
        n_tent    = tent;
        n_tent_er = tent_er;
        if (stb && hunt && crs && rxd == 2'b01) begin
            n_have   = 1'b1;
            n_low    = rxd;
            n_low_er = phy2rmii_rx_er;
            n_pend   = 1'b0;
        end else if (stb && hunt && crs && rxd == 2'b10) begin
            emit  = 1'b1;
            o_rxd = 4'he;
            o_er  = 1'b1;
        end else if (stb && state == DATA) begin
            if (!crs && pend) begin
                emit   = 1'b1;
                n_pend = 1'b0;
                n_have = 1'b0;
            end else if (!crs) begin
                n_pend    = 1'b1;
                n_tent    = rxd;
                n_tent_er = phy2rmii_rx_er;
            end else if (pend && have_low) begin
                emit     = 1'b1;
                o_dv     = 1'b1;
                o_rxd    = {tent, low};
                o_er     = tent_er | low_er;
                n_pend   = 1'b0;
                n_low    = rxd;
                n_low_er = phy2rmii_rx_er;
            end else if (pend) begin
                emit   = 1'b1;
                o_dv   = 1'b1;
                o_rxd  = {rxd, tent};
                o_er   = phy2rmii_rx_er | tent_er;
                n_pend = 1'b0;
            end else if (have_low) begin
                emit   = 1'b1;
                o_dv   = 1'b1;
                o_rxd  = {rxd, low};
                o_er   = phy2rmii_rx_er | low_er;
                n_have = 1'b0;
            end else begin
                n_have   = 1'b1;
                n_low    = rxd;
                n_low_er = phy2rmii_rx_er;
            end
        end
    end

    // Assembly state and MII outputs; outputs hold between strobes
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            mii_rxd       <= 4'h0;
            mii_rx_dv     <= 1'b0;
            mii_rx_er     <= 1'b0;
            mii_rx_clk_en <= 1'b0;
            have_low      <= 1'b0;
            low           <= 2'b00;
            low_er        <= 1'b0;
            pend          <= 1'b0;
            tent          <= 2'b00;
            tent_er       <= 1'b0;
        end else begin
            mii_rx_clk_en <= emit;
            if (emit) begin
                mii_rxd   <= o_rxd;
                mii_rx_dv <= o_dv;
                mii_rx_er <= o_er;
            end
            have_low <= n_have;
            low      <= n_low;
            low_er   <= n_low_er;
            pend     <= n_pend;
            tent     <= n_tent;
            tent_er  <= n_tent_er;
        end
    end

`ifdef RMII_RX_STATS_EN
    logic ferr;

    // Frame and error statistics; one error count per frame at most
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
            ferr      <= 1'b0;
        end else begin
            ferr <= (nxt == DATA && state != DATA) ? 1'b0 : ferr | (emit & o_er);
            if (state == DATA && nxt == IDLE) begin
                frame_cnt <= frame_cnt + STAT_W'(1);
                if (ferr | have_low) err_cnt <= err_cnt + STAT_W'(1);
            end else if (nxt == FALSE_CARRIER && state != FALSE_CARRIER) begin
                err_cnt <= err_cnt + STAT_W'(1);
            end
        end
    end
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif
endmodule

// File: tb/tb_rmii_rx_to_mii.sv
// tb_rmii_rx_to_mii: directed frames at both speeds, toggling end, errors, false carrier and mid-frame reset
module tb_rmii_rx_to_mii;
`ifdef RMII_RX_STATS_EN
    localparam int ST = 1;
`else
    localparam int ST = 0;
`endif

    logic        sys_clk = 1'b0;
    logic        reset = 1'b0;
    logic        crs = 1'b0;
    logic        rx_er = 1'b0;
    logic [1:0]  rxd = 2'b00;
    logic        speed = 1'b1;
    logic [3:0]  mii_rxd;
    logic        mii_rx_dv, mii_rx_er, mii_rx_clk_en;
    logic [15:0] frame_cnt, err_cnt;

    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    int          t0 = 0;
    logic [3:0]  dq[$];
    logic [5:0]  eq[$];
    logic [5:0]  cq[$];
    int          tq[$];

    rmii_rx_to_mii dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .phy2rmii_crs_dv(crs),
        .phy2rmii_rx_er(rx_er),
        .phy2rmii_rxd(rxd),
        .speed_100(speed),
        .mii_rxd(mii_rxd),
        .mii_rx_dv(mii_rx_dv),
        .mii_rx_er(mii_rx_er),
        .mii_rx_clk_en(mii_rx_clk_en),
        .frame_cnt(frame_cnt),
        .err_cnt(err_cnt)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) ncyc <= ncyc + 1;

    // Capture every strobe as {dv, er, nibble} with its cycle index
    always @(negedge sys_clk) begin
        if (!reset && mii_rx_clk_en) begin
            cq.push_back({mii_rx_dv, mii_rx_er, mii_rxd});
            tq.push_back(ncyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add(input logic c, input logic [1:0] d, input logic e);
        dq.push_back({e, c, d});
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 0; i < 4; i++) add(1'b1, b[2*i +: 2], 1'b0);
    endtask

    task automatic want(input logic dv, input logic er, input logic [3:0] n);
        eq.push_back({dv, er, n});
    endtask

    task automatic head();
        dq.delete();
        eq.delete();
        for (int i = 0; i < 7; i++) add_byte(8'h55);
        add_byte(8'hd5);
        add_byte(8'h12);
        for (int i = 0; i < 15; i++) want(1'b1, 1'b0, 4'h5);
        want(1'b1, 1'b0, 4'hd);
        want(1'b1, 1'b0, 4'h2);
        want(1'b1, 1'b0, 4'h1);
    endtask

    task automatic tail();
        for (int i = 0; i < 5; i++) add(1'b0, 2'b00, 1'b0);
        want(1'b0, 1'b0, 4'h0);
    endtask

    task automatic std_frame();
        head();
        add_byte(8'h34);
        want(1'b1, 1'b0, 4'h4);
        want(1'b1, 1'b0, 4'h3);
        tail();
    endtask

    task automatic play(input int a, input int b);
        for (int i = a; i < b; i++) begin
            {rx_er, crs, rxd} = dq[i];
            if (i == a) t0 = ncyc;
            repeat (speed ? 1 : 10) @(negedge sys_clk);
        end
    endtask

    task automatic run(input string tag);
        cq.delete();
        tq.delete();
        play(0, dq.size());
        check({tag, "_count"}, cq.size(), eq.size());
        foreach (eq[i]) if (i < cq.size()) check($sformatf("%s_nib%0d", tag, i), cq[i], eq[i]);
    endtask

    initial begin
        #5 reset = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_rxd", mii_rxd, 0);
        check("rst_dv", mii_rx_dv, 0);
        check("rst_er", mii_rx_er, 0);
        check("rst_en", mii_rx_clk_en, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        reset = 1'b0;
        repeat (3) @(negedge sys_clk);

        std_frame();
        run("fast");
        check("fast_frame_cnt", frame_cnt, ST * 1);
        check("fast_err_cnt", err_cnt, 0);

        speed = 1'b0;
        @(negedge sys_clk);
        std_frame();
        run("slow");
        if (tq.size() >= 16) begin
            check("slow_first_lat", tq[0] - t0, 16);
            for (int i = 1; i < 16; i++) check($sformatf("slow_space%0d", i), tq[i] - tq[i-1], 20);
        end
        check("slow_frame_cnt", frame_cnt, ST * 2);

        speed = 1'b1;
        @(negedge sys_clk);
        head();
        add(1'b0, 2'b00, 1'b0);
        add(1'b1, 2'b01, 1'b0);
        add(1'b0, 2'b11, 1'b0);
        add(1'b1, 2'b00, 1'b0);
        want(1'b1, 1'b0, 4'h4);
        want(1'b1, 1'b0, 4'h3);
        tail();
        run("toggle");
        check("toggle_frame_cnt", frame_cnt, ST * 3);
        check("toggle_err_cnt", err_cnt, 0);

        head();
        add(1'b1, 2'b00, 1'b0);
        add(1'b1, 2'b01, 1'b1);
        add(1'b1, 2'b11, 1'b0);
        add(1'b1, 2'b00, 1'b0);
        add(1'b1, 2'b11, 1'b0);
        want(1'b1, 1'b1, 4'h4);
        want(1'b1, 1'b0, 4'h3);
        tail();
        run("rxerr");
        check("rxerr_frame_cnt", frame_cnt, ST * 4);
        check("rxerr_err_cnt", err_cnt, ST * 1);

        dq.delete();
        eq.delete();
        add(1'b1, 2'b00, 1'b0);
        add(1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 6; i++) add(1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) add(1'b0, 2'b00, 1'b0);
        want(1'b0, 1'b1, 4'he);
        run("fcar");
        check("fcar_frame_cnt", frame_cnt, ST * 4);
        check("fcar_err_cnt", err_cnt, ST * 2);

        std_frame();
        cq.delete();
        play(0, 10);
        check("pre_rst_dv", mii_rx_dv, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_rxd", mii_rxd, 0);
        check("mid_rst_dv", mii_rx_dv, 0);
        check("mid_rst_en", mii_rx_clk_en, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        check("mid_rst_err_cnt", err_cnt, 0);
        @(negedge sys_clk);
        reset = 1'b0;
        cq.delete();
        play(10, dq.size());
        check("post_rst_no_strobe", cq.size(), 0);
        run("fresh");
        check("fresh_frame_cnt", frame_cnt, ST * 1);
        check("fresh_err_cnt", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
